bit_serial_adder: RTL

//  Multi-cycle adder: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and adds them LSB-first,
//  one bit per clock, through a single 1-bit full-adder cell with a registered carry.

---
 rtl/bit_serial_adder_pkg.sv | 8 +
 rtl/bit_serial_adder_if.sv | 25 ++
 rtl/bit_serial_adder_full_adder.sv | 11 +
 rtl/bit_serial_adder.sv | 113 +++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings.
package bit_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/bit_serial_adder_full_adder.sv
// The 1-bit full-adder cell that the serial adder reuses every cycle.
module bit_serial_adder_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one full-adder cell, registered carry, valid/ready on both sides.
// Optional macro SERIAL_ADDER_OVF_EN adds a signed-overflow flag register; otherwise ovf is tied 0.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    bit_serial_adder_if.slave   bus,
    output logic                busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] count;
    logic             carry;
    logic             cout_q;
    logic             cell_s;
    logic             cell_co;
    logic             last_bit;

    bit_serial_adder_full_adder u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // New sum bits enter at the MSB so the LSB computed first ends up at bit 0.
    generate
        if (WIDTH == 1) begin : g_acc1
            assign acc_next = cell_s;
        end else begin : g_accn
            assign acc_next = {cell_s, acc[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            sum_q  <= '0;
            count  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        count <= '0;
                        acc   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= cell_co;
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (last_bit) begin
                        sum_q  <= acc_next;
                        cout_q <= cell_co;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Overflow is the carry into the MSB differing from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == ST_RUN && last_bit) begin
            ovf_q <= carry ^ cell_co;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign busy          = (state == ST_RUN);
endmodule
